branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Owns the program counter and sequences conditional-branch resolution for the datapath.
- On a branch request it drives the condition flip-flop's enable, samples the taken/not-taken result, and applies the sign-extended IR offset to the PC.
- Sits directly downstream of the condition flip-flop, consuming its output, and upstream of the PC bus driver and memory-address path.
- Also handles sequential PC increment and direct PC load for jumps.

Parameters:
- WIDTH, 32, datapath/PC width
- OFF_W, 19, branch offset field width (IR[18:0])
- RESET_PC, 32'h0000_0000, PC value after reset

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  synchronous active-low reset
- ir  in  WIDTH  current instruction register
- pc_inc  in  1  increment PC by 1 (fetch)
- pc_ld  in  1  load PC from pc_in (jump/jal)
- pc_in  in  WIDTH  load value
- br_req  in  1  start branch resolution (1-cycle pulse, IDLE only)
- con_en  out  1  enable to condition flip-flop
- con_taken  in  1  condition result from condition flip-flop
- pc  out  WIDTH  current PC
- br_busy  out  1  high in any state other than IDLE
- br_done  out  1  one-cycle pulse when a branch resolves
- br_taken  out  1  registered result of the last resolved branch

Behaviour:
- Reset (clear=0 at a clock edge):
  - pc=RESET_PC, state=IDLE, con_en=0, br_busy=0, br_done=0, br_taken=0.
  - Reset overrides all other inputs, including mid-branch.
- FSM states: IDLE -> EVAL -> SAMPLE -> UPDATE -> IDLE.
- IDLE:
  - pc_ld=1: pc<=pc_in. This has priority over pc_inc.
  - Otherwise pc_inc=1: pc<=pc+1, wrapping modulo 2^WIDTH (32'hFFFF_FFFF+1=0).
  - br_req=1: go to EVAL. If pc_inc is also high, the increment is applied in the same cycle and the branch target is computed from the incremented PC.
- EVAL: con_en=1 for this cycle. Go to SAMPLE.
- SAMPLE:
  - con_en held at 1 so the condition flip-flop output is stable.
  - Register con_taken into br_taken. Go to UPDATE.
- UPDATE:
  - con_en=0; br_done=1 for exactly one cycle.
  - If br_taken: pc<=pc+sext(ir[OFF_W-1:0]). Signed, wraps modulo 2^WIDTH.
  - Otherwise pc is unchanged. Go to IDLE.
- Branch latency: br_req to br_done is 3 cycles. The PC reflects the target on the cycle after br_done.
- While busy:
  - pc_inc and br_req are ignored; no queuing.
  - pc_ld=1 aborts the branch: pc<=pc_in, state<=IDLE, con_en<=0, no br_done, br_taken unchanged.
- ir must be stable from br_req until UPDATE. The block does not latch ir.
- All outputs are registered except br_busy, which is decoded from state.

Optional Feature:
- Macro: BRANCH_PC_STATS_EN.
- With the macro defined:
  - Adds outputs br_total_cnt [15:0] and br_taken_cnt [15:0].
  - Both increment in UPDATE (taken count only when br_taken) and saturate at 16'hFFFF.
  - Both reset to 0 on clear; aborted branches are not counted.
- Without it: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'b00, EVAL=2'b01, SAMPLE=2'b10, UPDATE=2'b11)
  - Condition-field position constants (IR[20:19])
  - Offset field constants (OFF_MSB=18, OFF_LSB=0)
- One sub-module is natural: pc_target_adder. It is combinational: sign-extends the OFF_W-bit offset and adds it to the PC, giving the WIDTH-bit wrapped sum.

Test Plan:
- Reset then 3 pc_inc pulses -> pc=0,1,2,3. pc_ld with pc_in=32'hFFFF_FFFF, then pc_inc -> pc=0.
- pc=32'h100, ir[18:0]=19'h00010, br_req with con_taken=1 -> con_en high 2 cycles, br_done pulse 3 cycles after br_req, pc=32'h110, br_taken=1.
- Same branch with con_taken=0 -> br_done pulse, pc stays 32'h100, br_taken=0.
- Negative offset: pc=32'h100, ir[18:0]=19'h7FFF0 (-16), taken -> pc=32'hF0.
- Abort: branch started, pc_ld=1 with pc_in=32'h40 in SAMPLE -> pc=32'h40, IDLE next cycle, no br_done, con_en=0. Separately, clear=0 during EVAL -> all outputs at reset values.
- br_req with pc_inc in IDLE at pc=32'h20, offset 4, taken -> pc=32'h25. pc_inc and br_req while busy -> ignored.

Source files
------------

// File: rtl/branch_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_pc_unit_pkg
// Shared definitions for the branch/PC sequencer:
//   - state_t       : branch FSM state encoding
//   - COND_MSB/LSB  : IR condition-field position (decoded upstream by the
//                     condition flip-flop, listed here so both sides agree)
//   - OFF_MSB/LSB   : IR branch-offset field position
//   - sat_inc16     : saturating 16-bit increment used by the optional
//                     statistics counters
// ---------------------------------------------------------------------------
package branch_pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EVAL   = 2'b01,
        ST_SAMPLE = 2'b10,
        ST_UPDATE = 2'b11
    } state_t;

    localparam int COND_MSB = 20;
    localparam int COND_LSB = 19;

    localparam int OFF_MSB  = 18;
    localparam int OFF_LSB  = 0;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// ---------------------------------------------------------------------------
// branch_pc_unit_if
// Bus bundle between the datapath controller and the branch/PC unit.
//   ir         : current instruction register
//   pc_inc     : increment PC (fetch)
//   pc_ld      : load PC from pc_in (jump/jal, or abort of a pending branch)
//   pc_in      : load value
//   br_req     : one-cycle branch request, honoured only when idle
//   con_en     : enable towards the condition flip-flop
//   con_taken  : condition flip-flop result
//   pc         : current program counter
//   br_busy    : branch sequence in progress
//   br_done    : one-cycle pulse when a branch resolves
//   br_taken   : result of the last resolved branch
//   br_total_cnt / br_taken_cnt : statistics, only with BRANCH_PC_STATS_EN
// Modports: master = controller side, slave = branch_pc_unit side.
// ---------------------------------------------------------------------------
interface branch_pc_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] ir;
    logic             pc_inc;
    logic             pc_ld;
    logic [WIDTH-1:0] pc_in;
    logic             br_req;
    logic             con_en;
    logic             con_taken;
    logic [WIDTH-1:0] pc;
    logic             br_busy;
    logic             br_done;
    logic             br_taken;
`ifdef BRANCH_PC_STATS_EN
    logic [15:0]      br_total_cnt;
    logic [15:0]      br_taken_cnt;
`endif

    modport master (
        output ir, pc_inc, pc_ld, pc_in, br_req, con_taken,
`ifdef BRANCH_PC_STATS_EN
        input  br_total_cnt, br_taken_cnt,
`endif
        input  con_en, pc, br_busy, br_done, br_taken
    );

    modport slave (
        input  ir, pc_inc, pc_ld, pc_in, br_req, con_taken,
`ifdef BRANCH_PC_STATS_EN
        output br_total_cnt, br_taken_cnt,
`endif
        output con_en, pc, br_busy, br_done, br_taken
    );

endinterface

// File: rtl/branch_pc_unit_pc_target_adder.sv
// ---------------------------------------------------------------------------
// branch_pc_unit_pc_target_adder
// Combinational branch-target adder: sign-extends an OFF_W-bit offset to
// WIDTH bits and adds it to the PC. The sum wraps modulo 2^WIDTH.
//   pc     : current program counter
//   off    : raw offset field from the instruction
//   target : pc + sext(off)
// ---------------------------------------------------------------------------
module branch_pc_unit_pc_target_adder #(
    parameter int WIDTH = 32,
    parameter int OFF_W = 19
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [OFF_W-1:0] off,
    output logic [WIDTH-1:0] target
);

    logic [WIDTH-1:0] off_sext;

    // Low bits come straight from the field, everything above replicates
    // the field's sign bit.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sext
            if (gi < OFF_W) begin : g_field
                assign off_sext[gi] = off[gi];
            end else begin : g_sign
                assign off_sext[gi] = off[OFF_W-1];
            end
        end
    endgenerate

    assign target = pc + off_sext;

endmodule

// File: rtl/branch_pc_unit.sv
// ---------------------------------------------------------------------------
// branch_pc_unit
// Owns the program counter and sequences conditional-branch resolution.
//
// Ports:
//   clock : system clock, rising edge
//   clear : synchronous active-low reset
//   bus   : branch_pc_unit_if.slave (see interface file for signal list)
//
// Branch sequence IDLE -> EVAL -> SAMPLE -> UPDATE -> IDLE:
//   EVAL   : con_en high, condition flip-flop evaluates
//   SAMPLE : con_en still high, con_taken captured into br_taken
//   UPDATE : br_done pulses; PC takes the target on the way out if taken
// A pc_ld while busy aborts the branch (no br_done, br_taken untouched).
// ir is not latched; the controller holds it stable through UPDATE.
//
// Optional build macro BRANCH_PC_STATS_EN adds saturating 16-bit
// br_total_cnt / br_taken_cnt counters of completed branches.
// ---------------------------------------------------------------------------
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               OFF_W    = 19,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              clear,
    branch_pc_unit_if.slave   bus
);

    state_t           state_reg;
    logic [WIDTH-1:0] pc_reg;
    logic             con_en_reg;
    logic             br_done_reg;
    logic             br_taken_reg;
    logic [WIDTH-1:0] target_next;

    // Only the offset field is consumed here; the condition field
    // (COND_MSB:COND_LSB) is decoded by the condition flip-flop upstream.
    logic             unused_ir;
    assign unused_ir = ^bus.ir[WIDTH-1:OFF_LSB+OFF_W];

    branch_pc_unit_pc_target_adder #(
        .WIDTH (WIDTH),
        .OFF_W (OFF_W)
    ) u_pc_target_adder (
        .pc     (pc_reg),
        .off    (bus.ir[OFF_LSB +: OFF_W]),
        .target (target_next)
    );

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_PC;
            con_en_reg   <= 1'b0;
            br_done_reg  <= 1'b0;
            br_taken_reg <= 1'b0;
        end else begin
            br_done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    // Load wins over increment. A simultaneous br_req sees
                    // the updated PC as its base in UPDATE.
                    if (bus.pc_ld) begin
                        pc_reg <= bus.pc_in;
                    end else if (bus.pc_inc) begin
                        pc_reg <= pc_reg + WIDTH'(1);
                    end
                    if (bus.br_req) begin
                        state_reg  <= ST_EVAL;
                        con_en_reg <= 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (bus.pc_ld) begin
                        pc_reg     <= bus.pc_in;
                        state_reg  <= ST_IDLE;
                        con_en_reg <= 1'b0;
                    end else begin
                        // Keep con_en high through SAMPLE so the flip-flop
                        // output is stable when captured.
                        state_reg  <= ST_SAMPLE;
                        con_en_reg <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    con_en_reg <= 1'b0;
                    if (bus.pc_ld) begin
                        pc_reg    <= bus.pc_in;
                        state_reg <= ST_IDLE;
                    end else begin
                        br_taken_reg <= bus.con_taken;
                        br_done_reg  <= 1'b1;
                        state_reg    <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    state_reg <= ST_IDLE;
                    if (bus.pc_ld) begin
                        pc_reg <= bus.pc_in;
                    end else if (br_taken_reg) begin
                        pc_reg <= target_next;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    con_en_reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_PC_STATS_EN
    logic [15:0] br_total_cnt_reg;
    logic [15:0] br_taken_cnt_reg;

    // A branch counts when it leaves UPDATE normally; a pc_ld abort in
    // UPDATE is treated like any other abort and not counted.
    always_ff @(posedge clock) begin
        if (!clear) begin
            br_total_cnt_reg <= 16'd0;
            br_taken_cnt_reg <= 16'd0;
        end else if (state_reg == ST_UPDATE && !bus.pc_ld) begin
            br_total_cnt_reg <= sat_inc16(br_total_cnt_reg);
            if (br_taken_reg) begin
                br_taken_cnt_reg <= sat_inc16(br_taken_cnt_reg);
            end
        end
    end

    assign bus.br_total_cnt = br_total_cnt_reg;
    assign bus.br_taken_cnt = br_taken_cnt_reg;
`endif

    assign bus.pc       = pc_reg;
    assign bus.con_en   = con_en_reg;
    assign bus.br_done  = br_done_reg;
    assign bus.br_taken = br_taken_reg;
    assign bus.br_busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_branch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_pc_unit
// Directed bench for branch_pc_unit: reset, increment/load/wrap, taken and
// not-taken branches with positive, negative and extreme offsets, abort by
// pc_ld, reset mid-branch, and fetch combined with a branch request.
// ---------------------------------------------------------------------------
module tb_branch_pc_unit;

    logic clock;
    logic clear;
    int   n_assert;
    int   n_fail;

    branch_pc_unit_if #(.WIDTH(32)) bus_if ();

    branch_pc_unit #(
        .WIDTH    (32),
        .OFF_W    (19),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic load_pc(input logic [31:0] value);
        bus_if.pc_ld = 1'b1;
        bus_if.pc_in = value;
        tick();
        bus_if.pc_ld = 1'b0;
        chk32("load_pc", bus_if.pc, value);
    endtask

    // Full branch from a freshly loaded PC, checking every stage.
    task automatic run_branch(input string tag, input logic [31:0] start_pc,
                              input logic [31:0] ir_val, input logic taken,
                              input logic [31:0] exp_pc);
        load_pc(start_pc);
        bus_if.ir        = ir_val;
        bus_if.con_taken = taken;
        bus_if.br_req    = 1'b1;
        tick();
        bus_if.br_req = 1'b0;
        chk1({tag, ".eval.con_en"}, bus_if.con_en, 1'b1);
        chk1({tag, ".eval.busy"}, bus_if.br_busy, 1'b1);
        chk1({tag, ".eval.done"}, bus_if.br_done, 1'b0);
        tick();
        chk1({tag, ".sample.con_en"}, bus_if.con_en, 1'b1);
        chk1({tag, ".sample.done"}, bus_if.br_done, 1'b0);
        tick();
        chk1({tag, ".update.con_en"}, bus_if.con_en, 1'b0);
        chk1({tag, ".update.done"}, bus_if.br_done, 1'b1);
        chk1({tag, ".update.taken"}, bus_if.br_taken, taken);
        chk32({tag, ".update.pc"}, bus_if.pc, start_pc);
        tick();
        chk1({tag, ".idle.done"}, bus_if.br_done, 1'b0);
        chk1({tag, ".idle.busy"}, bus_if.br_busy, 1'b0);
        chk32({tag, ".idle.pc"}, bus_if.pc, exp_pc);
        $display("branch %s: pc %h -> %h taken=%b", tag, start_pc, bus_if.pc, taken);
    endtask

    initial begin
        n_assert         = 0;
        n_fail           = 0;
        clear            = 1'b0;
        bus_if.ir        = '0;
        bus_if.pc_inc    = 1'b0;
        bus_if.pc_ld     = 1'b0;
        bus_if.pc_in     = '0;
        bus_if.br_req    = 1'b0;
        bus_if.con_taken = 1'b0;

        // Reset state
        tick();
        tick();
        chk32("rst.pc", bus_if.pc, 32'h0);
        chk1("rst.con_en", bus_if.con_en, 1'b0);
        chk1("rst.busy", bus_if.br_busy, 1'b0);
        chk1("rst.done", bus_if.br_done, 1'b0);
        chk1("rst.taken", bus_if.br_taken, 1'b0);
        $display("reset: pc=%h", bus_if.pc);

        // Sequential increment 0 -> 1 -> 2 -> 3
        clear         = 1'b1;
        bus_if.pc_inc = 1'b1;
        tick();
        chk32("inc1", bus_if.pc, 32'h1);
        tick();
        chk32("inc2", bus_if.pc, 32'h2);
        tick();
        chk32("inc3", bus_if.pc, 32'h3);
        bus_if.pc_inc = 1'b0;
        $display("increment: pc=%h", bus_if.pc);

        // Load beats increment, then wrap at all-ones
        bus_if.pc_inc = 1'b1;
        bus_if.pc_ld  = 1'b1;
        bus_if.pc_in  = 32'hFFFF_FFFF;
        tick();
        bus_if.pc_ld = 1'b0;
        chk32("ld_prio", bus_if.pc, 32'hFFFF_FFFF);
        tick();
        bus_if.pc_inc = 1'b0;
        chk32("wrap", bus_if.pc, 32'h0);
        $display("load+wrap: pc=%h", bus_if.pc);

        // Branches: taken +16, -16 (upper IR bits noisy), max positive,
        // most negative, and not-taken.
        run_branch("taken_pos", 32'h100, 32'h0000_0010, 1'b1, 32'h110);
        run_branch("taken_neg", 32'h100, 32'hABC7_FFF0, 1'b1, 32'hF0);
        run_branch("max_pos", 32'h0, 32'h0003_FFFF, 1'b1, 32'h0003_FFFF);
        run_branch("min_neg", 32'h100, 32'h0004_0000, 1'b1, 32'hFFFC_0100);
        run_branch("not_taken", 32'h100, 32'h0000_0010, 1'b0, 32'h100);

        // Abort with pc_ld during SAMPLE; br_taken keeps the not-taken value
        load_pc(32'h100);
        bus_if.ir        = 32'h0000_0010;
        bus_if.con_taken = 1'b1;
        bus_if.br_req    = 1'b1;
        tick();
        bus_if.br_req = 1'b0;
        tick();
        chk1("abort.sample.con_en", bus_if.con_en, 1'b1);
        bus_if.pc_ld = 1'b1;
        bus_if.pc_in = 32'h40;
        tick();
        bus_if.pc_ld = 1'b0;
        chk32("abort.pc", bus_if.pc, 32'h40);
        chk1("abort.busy", bus_if.br_busy, 1'b0);
        chk1("abort.con_en", bus_if.con_en, 1'b0);
        chk1("abort.done", bus_if.br_done, 1'b0);
        chk1("abort.taken", bus_if.br_taken, 1'b0);
        tick();
        chk1("abort.after.done", bus_if.br_done, 1'b0);
        chk32("abort.after.pc", bus_if.pc, 32'h40);
        $display("abort: pc=%h busy=%b", bus_if.pc, bus_if.br_busy);

        // pc_inc with br_req at 0x20, offset 4: base becomes 0x21 -> 0x25.
        // pc_inc/br_req stay high while busy and must be ignored.
        load_pc(32'h20);
        bus_if.ir        = 32'h0000_0004;
        bus_if.con_taken = 1'b1;
        bus_if.pc_inc    = 1'b1;
        bus_if.br_req    = 1'b1;
        tick();
        chk32("incbr.eval.pc", bus_if.pc, 32'h21);
        chk1("incbr.eval.busy", bus_if.br_busy, 1'b1);
        tick();
        chk32("incbr.sample.pc", bus_if.pc, 32'h21);
        chk1("incbr.sample.con_en", bus_if.con_en, 1'b1);
        tick();
        chk1("incbr.update.done", bus_if.br_done, 1'b1);
        chk32("incbr.update.pc", bus_if.pc, 32'h21);
        bus_if.pc_inc = 1'b0;
        bus_if.br_req = 1'b0;
        tick();
        chk32("incbr.idle.pc", bus_if.pc, 32'h25);
        chk1("incbr.idle.taken", bus_if.br_taken, 1'b1);
        tick();
        chk1("incbr.noqueue.busy", bus_if.br_busy, 1'b0);
        chk32("incbr.noqueue.pc", bus_if.pc, 32'h25);
        $display("inc+branch: pc=%h", bus_if.pc);
`ifdef BRANCH_PC_STATS_EN
        chk32("stats.total", {16'h0, bus_if.br_total_cnt}, 32'd6);
        chk32("stats.taken", {16'h0, bus_if.br_taken_cnt}, 32'd5);
`endif

        // Reset during EVAL clears everything
        bus_if.ir        = 32'h0000_0010;
        bus_if.con_taken = 1'b1;
        bus_if.br_req    = 1'b1;
        tick();
        bus_if.br_req = 1'b0;
        chk1("clr.eval.con_en", bus_if.con_en, 1'b1);
        clear = 1'b0;
        tick();
        chk32("clr.pc", bus_if.pc, 32'h0);
        chk1("clr.con_en", bus_if.con_en, 1'b0);
        chk1("clr.busy", bus_if.br_busy, 1'b0);
        chk1("clr.done", bus_if.br_done, 1'b0);
        chk1("clr.taken", bus_if.br_taken, 1'b0);
`ifdef BRANCH_PC_STATS_EN
        chk32("clr.stats.total", {16'h0, bus_if.br_total_cnt}, 32'd0);
        chk32("clr.stats.taken", {16'h0, bus_if.br_taken_cnt}, 32'd0);
`endif
        clear = 1'b1;
        tick();
        chk1("clr.after.busy", bus_if.br_busy, 1'b0);
        chk1("clr.after.done", bus_if.br_done, 1'b0);
        $display("clear mid-branch: pc=%h busy=%b", bus_if.pc, bus_if.br_busy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
